// File: rtl/spk_readout.sv
// Output-layer readout: snoops spike-SRAM writes to one word address, counts
// spikes per output neuron over an inference, then picks the winning class
// with a sequential argmax and hands it to the host over valid/ready.
//
// state  | meaning
// IDLE   | waiting for start; snooped writes ignored
// ACCUM  | counting hits on the latched address until the last step_done
// ARGMAX | scanning one neuron index per cycle, ties keep the lower index
// DONE   | result_valid high until result_ready
module spk_readout #(
    parameter int N_OUT  = 16,
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 8,
    parameter int STEP_W = 8,
    parameter int CLS_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_out_addr,
    input  logic [STEP_W-1:0] cfg_num_steps,
    input  logic              step_done,
    input  logic [N_OUT-1:0]  spk_write_sram,
    input  logic [ADDR_W-1:0] spk_write_sram_addr,
    input  logic              spk_write_sram_we,
    output logic              busy,
    output logic [CLS_W-1:0]  result_class,
    output logic [CNT_W-1:0]  result_count,
    output logic              result_valid,
    input  logic              result_ready
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_ARGMAX = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [STEP_W-1:0] steps_q;
    logic [STEP_W-1:0] step_cnt_q;
    logic [STEP_W-1:0] step_cnt_d;
    logic [CNT_W-1:0]  cnt_q [N_OUT];
    logic [CLS_W-1:0]  idx_q;
    logic [CLS_W-1:0]  best_cls_q;
    logic [CLS_W-1:0]  best_cls_d;
    logic [CNT_W-1:0]  best_cnt_q;
    logic [CNT_W-1:0]  best_cnt_d;
    logic [CNT_W-1:0]  cand;
    logic              hit;
    logic              busy_q;
    logic              valid_q;
    logic [CLS_W-1:0]  result_class_q;
    logic [CNT_W-1:0]  result_count_q;

    // Snoop match and step counter increment.
    always_comb begin
        hit        = spk_write_sram_we && (spk_write_sram_addr == addr_q);
        step_cnt_d = step_cnt_q + STEP_W'(1);
    end

    // Argmax step: index 0 always seeds the best; later indices must be strictly greater.
    always_comb begin
        cand       = cnt_q[idx_q];
        best_cls_d = best_cls_q;
        best_cnt_d = best_cnt_q;
        if ((idx_q == '0) || (cand > best_cnt_q)) begin
            best_cls_d = idx_q;
            best_cnt_d = cand;
        end
    end

    // Control FSM with counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            steps_q        <= '0;
            step_cnt_q     <= '0;
            idx_q          <= '0;
            best_cls_q     <= '0;
            best_cnt_q     <= '0;
            busy_q         <= 1'b0;
            valid_q        <= 1'b0;
            result_class_q <= '0;
            result_count_q <= '0;
            for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q     <= cfg_out_addr;
                        // A zero step count would never terminate; run one step instead.
                        steps_q    <= (cfg_num_steps == '0) ? STEP_W'(1) : cfg_num_steps;
                        step_cnt_q <= '0;
                        for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (hit) begin
                        for (int i = 0; i < N_OUT; i++) begin
                            if (spk_write_sram[i] && (cnt_q[i] != '1))
                                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                        end
                    end
                    if (step_done) begin
                        step_cnt_q <= step_cnt_d;
                        if (step_cnt_d == steps_q) begin
                            idx_q   <= '0;
                            state_q <= S_ARGMAX;
                        end
                    end
                end
                S_ARGMAX: begin
                    best_cls_q <= best_cls_d;
                    best_cnt_q <= best_cnt_d;
                    idx_q      <= idx_q + CLS_W'(1);
                    if (idx_q == CLS_W'(N_OUT - 1)) begin
                        result_class_q <= best_cls_d;
                        result_count_q <= best_cnt_d;
                        valid_q        <= 1'b1;
                        busy_q         <= 1'b0;
                        state_q        <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (result_ready) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign result_class = result_class_q;
    assign result_count = result_count_q;

endmodule

// File: tb/tb_spk_readout.sv
// Bench for spk_readout: directed table, hand sequences for the handshake,
// saturation and reset corners, and randomized inferences against a model.
module tb_spk_readout;

    localparam int N_OUT  = 16;
    localparam int ADDR_W = 9;
    localparam int CNT_W  = 8;
    localparam int STEP_W = 8;
    localparam int CLS_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] cfg_out_addr;
    logic [STEP_W-1:0] cfg_num_steps;
    logic              step_done;
    logic [N_OUT-1:0]  spk_write_sram;
    logic [ADDR_W-1:0] spk_write_sram_addr;
    logic              spk_write_sram_we;
    logic              busy;
    logic [CLS_W-1:0]  result_class;
    logic [CNT_W-1:0]  result_count;
    logic              result_valid;
    logic              result_ready;

    spk_readout #(
        .N_OUT(N_OUT), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .STEP_W(STEP_W), .CLS_W(CLS_W)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .cfg_out_addr        (cfg_out_addr),
        .cfg_num_steps       (cfg_num_steps),
        .step_done           (step_done),
        .spk_write_sram      (spk_write_sram),
        .spk_write_sram_addr (spk_write_sram_addr),
        .spk_write_sram_we   (spk_write_sram_we),
        .busy                (busy),
        .result_class        (result_class),
        .result_count        (result_count),
        .result_valid        (result_valid),
        .result_ready        (result_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain per-neuron spike totals, capped at 255.
    int mcnt [N_OUT];
    int cur_addr;

    typedef struct {
        logic [8:0]  addr;
        logic [7:0]  steps;
        logic [15:0] word;
        logic [15:0] extra;
        logic [15:0] noise;
        int          exp_cls;
        int          exp_cnt;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void m_clear();
        for (int i = 0; i < N_OUT; i++) mcnt[i] = 0;
    endfunction

    function automatic void m_best(output int cls, output int cnt);
        cls = 0;
        cnt = mcnt[0];
        for (int i = 1; i < N_OUT; i++) begin
            if (mcnt[i] > cnt) begin
                cls = i;
                cnt = mcnt[i];
            end
        end
    endfunction

    task automatic clear_inputs();
        start               = 1'b0;
        step_done           = 1'b0;
        spk_write_sram      = '0;
        spk_write_sram_addr = '0;
        spk_write_sram_we   = 1'b0;
        result_ready        = 1'b0;
    endtask

    task automatic do_start(input logic [8:0] a, input logic [7:0] s);
        start         = 1'b1;
        cfg_out_addr  = a;
        cfg_num_steps = s;
        tick();
        start    = 1'b0;
        cur_addr = int'(a);
        m_clear();
    endtask

    // One cycle of snooped write, optionally with step_done; model tracks matching hits.
    task automatic wr(input logic [8:0] a, input logic [15:0] d, input logic sd);
        spk_write_sram_we   = 1'b1;
        spk_write_sram_addr = a;
        spk_write_sram      = d;
        step_done           = sd;
        if (int'(a) == cur_addr) begin
            for (int i = 0; i < N_OUT; i++)
                if (d[i] && mcnt[i] < 255) mcnt[i]++;
        end
        tick();
        spk_write_sram_we = 1'b0;
        spk_write_sram    = '0;
        step_done         = 1'b0;
    endtask

    task automatic step();
        step_done = 1'b1;
        tick();
        step_done = 1'b0;
    endtask

    // Called right after the cycle carrying the final step_done; n counts that cycle as 1.
    task automatic wait_valid(output int n, input bit noise);
        n = 1;
        while (!result_valid && n < 64) begin
            if (noise) begin
                spk_write_sram_we   = 1'b1;
                spk_write_sram_addr = 9'(cur_addr);
                spk_write_sram      = 16'($urandom);
                step_done           = 1'b1;
                start               = 1'b1;
            end
            tick();
            n++;
        end
        clear_inputs();
        if (n >= 64) check("valid_timeout", 32'(n), 32'd17);
    endtask

    task automatic accept();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("valid_after_ready", 32'(result_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ecls, ecnt;
        int eff;

        vecs[0] = '{9'h1C0, 8'd3, 16'h0008, 16'h0000, 16'hFFFF, 3, 3};
        vecs[1] = '{9'h005, 8'd2, 16'h0024, 16'h0000, 16'hFFFF, 2, 2};
        vecs[2] = '{9'h1FF, 8'd5, 16'h8001, 16'h8000, 16'h7FFE, 15, 10};
        vecs[3] = '{9'h000, 8'd0, 16'h0000, 16'h0000, 16'hFFFF, 0, 0};
        vecs[4] = '{9'h0AA, 8'd4, 16'h0F00, 16'h0200, 16'hF0FF, 9, 8};
        vecs[5] = '{9'h123, 8'd1, 16'hFFFF, 16'h0000, 16'h0000, 0, 1};

        clear_inputs();
        cfg_out_addr  = '0;
        cfg_num_steps = '0;
        cur_addr      = -1;
        m_clear();
        reset = 1'b1;
        repeat (2) tick();
        check("rst_busy",  32'(busy),         32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_class", 32'(result_class), 32'd0);
        check("rst_count", 32'(result_count), 32'd0);
        reset = 1'b0;
        tick();

        // Basic classification, coincident final write, latency, hold and start-in-DONE.
        do_start(9'h1C0, 8'd4);
        check("busy_after_start", 32'(busy), 32'd1);
        wr(9'h1C0, 16'h0008, 1'b0); step();
        wr(9'h1C0, 16'h0008, 1'b0); wr(9'h1C0, 16'h0001, 1'b0); step();
        wr(9'h1C0, 16'h0008, 1'b0); wr(9'h1C0, 16'h0001, 1'b0); step();
        wr(9'h1C0, 16'h0008, 1'b1);
        check("valid_low_in_argmax", 32'(result_valid), 32'd0);
        check("busy_in_argmax",      32'(busy),         32'd1);
        wait_valid(n, 1'b0);
        check("basic_latency", 32'(n),            32'd17);
        check("basic_class",   32'(result_class), 32'd3);
        check("basic_count",   32'(result_count), 32'd4);
        check("basic_busy",    32'(busy),         32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", 32'(result_valid), 32'd1);
            check("hold_class", 32'(result_class), 32'd3);
            check("hold_count", 32'(result_count), 32'd4);
        end
        start = 1'b1; cfg_out_addr = 9'h000; cfg_num_steps = 8'd1;
        tick();
        start = 1'b0;
        check("done_start_valid", 32'(result_valid), 32'd1);
        check("done_start_busy",  32'(busy),         32'd0);
        start = 1'b1; result_ready = 1'b1;
        tick();
        start = 1'b0; result_ready = 1'b0;
        check("ready_start_valid", 32'(result_valid), 32'd0);
        check("ready_start_busy",  32'(busy),         32'd0);
        tick();
        check("idle_busy",      32'(busy),         32'd0);
        check("retained_class", 32'(result_class), 32'd3);
        check("retained_count", 32'(result_count), 32'd4);

        // Directed table: noise at a neighbouring address, activity during ARGMAX ignored.
        for (int v = 0; v < 6; v++) begin
            do_start(vecs[v].addr, vecs[v].steps);
            eff = (vecs[v].steps == 0) ? 1 : int'(vecs[v].steps);
            for (int s = 0; s < eff; s++) begin
                wr(vecs[v].addr, vecs[v].word, 1'b0);
                if (vecs[v].extra != 16'h0000) wr(vecs[v].addr, vecs[v].extra, 1'b0);
                wr(vecs[v].addr ^ 9'h001, vecs[v].noise, 1'b0);
                step();
            end
            wait_valid(n, 1'b1);
            check("tbl_latency", 32'(n),            32'd17);
            check("tbl_class",   32'(result_class), 32'(vecs[v].exp_cls));
            check("tbl_count",   32'(result_count), 32'(vecs[v].exp_cnt));
            accept();
        end

        // Saturation over 255 steps of three hits each on bit 15.
        do_start(9'h1C0, 8'd255);
        for (int s = 0; s < 255; s++) begin
            repeat (3) wr(9'h1C0, 16'h8000, 1'b0);
            step();
        end
        wait_valid(n, 1'b0);
        check("sat_class", 32'(result_class), 32'd15);
        check("sat_count", 32'(result_count), 32'd255);
        accept();

        // Randomized inferences against the model.
        for (int r = 0; r < 10; r++) begin
            logic [8:0] a;
            logic [7:0] s;
            a = 9'($urandom);
            s = 8'($urandom_range(0, 5));
            do_start(a, s);
            eff = (s == 0) ? 1 : int'(s);
            for (int k = 0; k < eff; k++) begin
                int  nw;
                bit  merged;
                nw     = $urandom_range(0, 3);
                merged = 1'b0;
                for (int w = 0; w < nw; w++) begin
                    logic [8:0] wa;
                    bit         sd;
                    wa = ($urandom_range(0, 2) != 0) ? a : 9'($urandom);
                    sd = (w == nw - 1) && ($urandom_range(0, 1) == 1);
                    wr(wa, 16'($urandom), sd);
                    if (sd) merged = 1'b1;
                end
                if (!merged) step();
            end
            wait_valid(n, 1'b1);
            m_best(ecls, ecnt);
            check("rnd_latency", 32'(n),            32'd17);
            check("rnd_class",   32'(result_class), 32'(ecls));
            check("rnd_count",   32'(result_count), 32'(ecnt));
            accept();
        end

        // Reset mid-inference, then a clean inference.
        do_start(9'h1C0, 8'd4);
        wr(9'h1C0, 16'hFFFF, 1'b0); step();
        wr(9'h1C0, 16'hFFFF, 1'b0); step();
        reset = 1'b1;
        #1;
        check("midrst_busy",  32'(busy),         32'd0);
        check("midrst_valid", 32'(result_valid), 32'd0);
        check("midrst_class", 32'(result_class), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        do_start(9'h1C0, 8'd2);
        wr(9'h1C0, 16'h0002, 1'b0); step();
        step();
        wait_valid(n, 1'b0);
        check("postrst_class", 32'(result_class), 32'd1);
        check("postrst_count", 32'(result_count), 32'd1);
        accept();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spk_readout.md
Name: spk_readout

Overview:
- Output-layer readout stage directly downstream of the accelerator core.
- Snoops the accelerator's spike-SRAM write port (spk_write_sram / spk_write_sram_addr / spk_write_sram_we). Over one inference of NUM_STEPS timesteps it counts spikes for each of the 16 output neurons stored at a configured word address.
- At the end of the inference it runs a sequential argmax and presents the winning class to the host with a valid/ready handshake.

Parameters:
- N_OUT, 16, output neurons per spike word; equals the spike word width.
- ADDR_W, 9, spike SRAM address width.
- CNT_W, 8, per-neuron spike counter width; counters saturate.
- STEP_W, 8, timestep counter width.
- CLS_W, 4, class index width; equals clog2(N_OUT).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins an inference; accepted only in IDLE.
- cfg_out_addr  in  ADDR_W  spike SRAM word address of the output layer; latched on accepted start.
- cfg_num_steps  in  STEP_W  number of timesteps per inference; latched on accepted start; value 0 is treated as 1.
- step_done  in  1  one-cycle pulse from the control unit at the end of each timestep.
- spk_write_sram  in  N_OUT  spike word being written, snooped.
- spk_write_sram_addr  in  ADDR_W  write address, snooped.
- spk_write_sram_we  in  1  write enable, snooped.
- busy  out  1  high in ACCUM and ARGMAX.
- result_class  out  CLS_W  index of the winning neuron.
- result_count  out  CNT_W  spike count of the winning neuron.
- result_valid  out  1  result available.
- result_ready  in  1  host accepts the result.

Behaviour:
- Reset (asynchronous): state=IDLE; all counters, step count, latched cfg and argmax registers = 0; busy=0, result_valid=0, result_class=0, result_count=0.
- States: IDLE, ACCUM, ARGMAX, DONE.
- IDLE:
  - start=1 → latch cfg, clear all N_OUT counters and the step count, go to ACCUM next cycle.
  - Writes seen in IDLE are ignored.
- ACCUM:
  - Hit condition: spk_write_sram_we=1 and spk_write_sram_addr==latched addr.
  - On a hit, each bit i of spk_write_sram that is 1 increments cnt[i]. Increments saturate at 2^CNT_W-1; there is no wrap.
  - Writes to any other address are ignored.
  - step_done=1 increments the step count.
  - When the incremented step count equals the latched cfg_num_steps, go to ARGMAX.
  - A hit and step_done in the same cycle: the hit is counted, including on the final step.
  - start is ignored.
- ARGMAX:
  - Scans index 0..N_OUT-1, one index per cycle, so it occupies exactly N_OUT cycles.
  - Best is initialised to index 0. Index k replaces best only if cnt[k] > best count (strictly greater), so ties resolve to the lowest index.
  - Snooped writes and step_done are ignored.
  - After index N_OUT-1 is evaluated, go to DONE.
- DONE:
  - result_valid=1; result_class and result_count are registered and held stable.
  - result_valid stays high until result_ready=1. On that cycle the transfer completes and the next state is IDLE with result_valid=0.
  - result_class and result_count retain their values until the next ARGMAX completes.
  - start is ignored in DONE, including when it coincides with result_ready.
- Latency: step_done finishing the last step at cycle t → ARGMAX during cycles t+1..t+N_OUT → result_valid=1 from cycle t+N_OUT+1.
- Reset asserted mid-operation in any state returns to the reset values immediately; partial counts are discarded.

Test Plan:
- Basic classification:
  - start with cfg_out_addr=9'h1C0, cfg_num_steps=4.
  - Per step, write 16'h0008 to 9'h1C0; in steps 2 and 3 also write 16'h0001.
  - Expected: result_class=3, result_count=4, result_valid rises exactly 17 cycles after the 4th step_done.
- Address filter and tie:
  - Writes of 16'hFFFF to 9'h1BF are ignored.
  - Writing 16'h0024 to 9'h1C0 twice gives cnt[2]=cnt[5]=2, result_class=2 (lowest index wins the tie).
- Saturation:
  - cfg_num_steps=255; write 16'h8000 to the output address 3 times per step.
  - Expected: result_class=15, result_count=255 (no wrap).
- Handshake and simultaneous events:
  - Write coincident with the final step_done is counted.
  - Hold result_ready=0 for 10 cycles: valid, class and count stay stable.
  - Pulse ready: valid drops next cycle and the block is back in IDLE.
  - A start pulse issued in DONE is ignored.
- Zero-step configuration:
  - cfg_num_steps=0 completes after the first step_done; behaves as 1.
- Reset mid-inference:
  - Assert reset during ACCUM after 2 of 4 steps: busy=0, result_valid=0 immediately.
  - A new inference then produces counts free of the pre-reset spikes.
